// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/funct
// constants, instruction classes and the combinational instruction classifier.
package uc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CLS_LD    = 2'd0,
        CLS_SD    = 2'd1,
        CLS_ALU_R = 2'd2,
        CLS_ALU_I = 2'd3
    } instr_class_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_DWORD = 3'b011;
    localparam logic [2:0] F3_ADD   = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef struct packed {
        logic         legal;
        instr_class_t cls;
        logic         sub;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3      = instr[14:12];
        f7      = instr[31:25];
        d.legal = 1'b0;
        d.cls   = CLS_ALU_I;
        d.sub   = 1'b0;
        case (instr[6:0])
            OPC_LOAD: begin
                d.cls   = CLS_LD;
                d.legal = (f3 == F3_DWORD);
            end
            OPC_STORE: begin
                d.cls   = CLS_SD;
                d.legal = (f3 == F3_DWORD);
            end
            OPC_OP: begin
                d.cls   = CLS_ALU_R;
                d.legal = (f3 == F3_ADD) && ((f7 == F7_ADD) || (f7 == F7_SUB));
                d.sub   = (f7 == F7_SUB);
            end
            OPC_OP_IMM: begin
                d.cls   = CLS_ALU_I;
                d.legal = (f3 == F3_ADD);
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/gerador_imediato.sv
// Immediate generator: I-type for loads/ADDI, S-type for stores, zero for R-type.
// Purely combinational; sign-extends the 12-bit field to XLEN (XLEN >= 12).
module gerador_imediato
    import uc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  instr_class_t    cls,
    output logic [XLEN-1:0] imm
);

    logic [11:0] imm12;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{instr[19:12], instr[6:0]};

    always_comb begin
        imm12 = 12'd0;
        case (cls)
            CLS_LD, CLS_ALU_I: imm12 = instr[31:20];
            CLS_SD:            imm12 = {instr[31:25], instr[11:7]};
            default:           imm12 = 12'd0;
        endcase
        imm = {{(XLEN-12){imm12[11]}}, imm12};
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing for LD, SD, ADD/SUB, ADDI.
// Enables are Moore outputs of the state; operand selects and fields latch in DECODE.
// Optional retired-instruction counter enabled with macro UC_INSTRET_EN (tied to 0 otherwise).
module unidade_controle
    import uc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [31:0]     instr,
    output logic            we_ir,
    output logic            we_pc,
    output logic            we_reg,
    output logic            we_mem,
    output logic            sel_mux1,
    output logic            sel_mux2,
    output logic            sinal,
    output logic [4:0]      ra,
    output logic [4:0]      rb,
    output logic [4:0]      rw,
    output logic [XLEN-1:0] imm,
    output logic            busy,
    output logic            illegal,
    output logic [63:0]     instret
);

    state_t          state_q, state_d;
    dec_t            dec;
    instr_class_t    cls_q;
    logic [XLEN-1:0] imm_d;
    logic            retire;

    assign dec = decode_instr(instr);

    gerador_imediato #(.XLEN(XLEN)) u_gerador_imediato (
        .instr (instr),
        .cls   (dec.cls),
        .imm   (imm_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fields latch once per instruction; selects only change for a legal one
    // so they stay stable from EXEC through MEM and WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra       <= 5'd0;
            rb       <= 5'd0;
            rw       <= 5'd0;
            imm      <= '0;
            cls_q    <= CLS_LD;
            sel_mux1 <= 1'b0;
            sel_mux2 <= 1'b0;
            sinal    <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            ra    <= instr[19:15];
            rb    <= instr[24:20];
            rw    <= instr[11:7];
            imm   <= imm_d;
            cls_q <= dec.cls;
            if (dec.legal) begin
                sel_mux1 <= (dec.cls == CLS_ALU_R);
                sel_mux2 <= (dec.cls == CLS_ALU_R) || (dec.cls == CLS_ALU_I);
                sinal    <= dec.sub;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we_ir   = 1'b0;
        we_pc   = 1'b0;
        we_reg  = 1'b0;
        we_mem  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                we_ir   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = dec.legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                state_d = ((cls_q == CLS_LD) || (cls_q == CLS_SD)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (cls_q == CLS_SD) begin
                    we_mem = 1'b1;
                    we_pc  = 1'b1;
                    retire = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                we_pc  = 1'b1;
                we_reg = (rw != 5'd0);
                retire = 1'b1;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign illegal = (state_q == ST_TRAP);

`ifdef UC_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 64'd0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench: expected per-cycle control vectors are queued per instruction
// and popped/compared each cycle; register fields and counters checked at key points.
module tb_unidade_controle;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [31:0] instr;
    logic        we_ir, we_pc, we_reg, we_mem;
    logic        sel_mux1, sel_mux2, sinal;
    logic [4:0]  ra, rb, rw;
    logic [63:0] imm;
    logic        busy, illegal;
    logic [63:0] instret;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [8:0] v;
        logic [8:0] m;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog[$];

    // vector bits: we_ir we_pc we_reg we_mem sel_mux1 sel_mux2 sinal busy illegal
    localparam logic [8:0] M_ALL   = 9'b111111111;
    localparam logic [8:0] M_NOSEL = 9'b111100011;
    localparam logic [8:0] M_NOS2  = 9'b111110111;

    localparam logic [8:0] V_IDLE   = 9'b000000000;
    localparam logic [8:0] V_FETCH  = 9'b100000010;
    localparam logic [8:0] V_DECODE = 9'b000000010;
    localparam logic [8:0] V_TRAP   = 9'b000000001;

`ifdef UC_INSTRET_EN
    localparam logic [63:0] RET4 = 64'd4;
    localparam logic [63:0] RET5 = 64'd5;
`else
    localparam logic [63:0] RET4 = 64'd0;
    localparam logic [63:0] RET5 = 64'd0;
`endif

    unidade_controle #(.XLEN(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .instr    (instr),
        .we_ir    (we_ir),
        .we_pc    (we_pc),
        .we_reg   (we_reg),
        .we_mem   (we_mem),
        .sel_mux1 (sel_mux1),
        .sel_mux2 (sel_mux2),
        .sinal    (sinal),
        .ra       (ra),
        .rb       (rb),
        .rw       (rw),
        .imm      (imm),
        .busy     (busy),
        .illegal  (illegal),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ovec();
        return {we_ir, we_pc, we_reg, we_mem, sel_mux1, sel_mux2, sinal, busy, illegal};
    endfunction

    task automatic push(input string tag, input logic [8:0] v, input logic [8:0] m);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.m   = m;
        exp_q.push_back(e);
    endtask

    // One clock; compare against the oldest expectation; model IR load on we_ir.
    task automatic tick();
        exp_t       e;
        logic [8:0] obs;
        @(posedge clk);
        @(negedge clk);
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            obs = ovec();
            n_assert++;
            assert ((obs & e.m) === (e.v & e.m)) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b mask %b", e.tag, obs & e.m, e.v & e.m, e.m);
            end
        end
        if (we_ir && prog.size() != 0) instr = prog.pop_front();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        instr = 32'd0;
        #3;
        chk("reset_vec", {55'd0, ovec()}, 64'd0);
        chk("reset_ra", {59'd0, ra}, 64'd0);
        chk("reset_rw", {59'd0, rw}, 64'd0);
        chk("reset_imm", imm, 64'd0);
        chk("reset_instret", instret, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        push("idle_run0", V_IDLE, M_ALL);
        tick();

        // ADD, SUB, LD, SD back to back
        run = 1'b1;
        prog.push_back(32'h001101B3);
        prog.push_back(32'h40308233);
        prog.push_back(32'h00803083);
        prog.push_back(32'hFE62BC23);

        push("add_fetch", V_FETCH, M_NOSEL);
        push("add_decode", V_DECODE, M_NOSEL);
        push("add_exec", 9'b000011010, M_ALL);
        push("add_wb", 9'b011011010, M_ALL);
        tick(); tick(); tick();
        chk("add_ra", {59'd0, ra}, 64'd2);
        chk("add_rb", {59'd0, rb}, 64'd1);
        chk("add_rw", {59'd0, rw}, 64'd3);
        tick();

        push("sub_fetch", V_FETCH, M_NOSEL);
        push("sub_decode", V_DECODE, M_NOSEL);
        push("sub_exec", 9'b000011110, M_ALL);
        push("sub_wb", 9'b011011110, M_ALL);
        tick(); tick(); tick();
        chk("sub_ra", {59'd0, ra}, 64'd1);
        chk("sub_rb", {59'd0, rb}, 64'd3);
        chk("sub_rw", {59'd0, rw}, 64'd4);
        tick();

        push("ld_fetch", V_FETCH, M_NOSEL);
        push("ld_decode", V_DECODE, M_NOSEL);
        push("ld_exec", 9'b000000010, M_ALL);
        push("ld_mem", 9'b000000010, M_ALL);
        push("ld_wb", 9'b011000010, M_ALL);
        tick(); tick(); tick();
        chk("ld_imm", imm, 64'd8);
        chk("ld_rw", {59'd0, rw}, 64'd1);
        tick(); tick();

        push("sd_fetch", V_FETCH, M_NOSEL);
        tick();
        run = 1'b0;
        push("sd_decode", V_DECODE, M_NOSEL);
        push("sd_exec", 9'b000000010, M_NOS2);
        push("sd_mem", 9'b010100010, M_NOS2);
        push("sd_retire_idle", V_IDLE, M_NOSEL);
        tick(); tick();
        chk("sd_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sd_ra", {59'd0, ra}, 64'd5);
        chk("sd_rb", {59'd0, rb}, 64'd6);
        tick(); tick();
        chk("instret_after_4", instret, RET4);
        chk("sd_ra_held", {59'd0, ra}, 64'd5);

        // ADD x0: PC advances, no register write
        run = 1'b1;
        prog.push_back(32'h00000033);
        push("addx0_fetch", V_FETCH, M_NOSEL);
        tick();
        run = 1'b0;
        push("addx0_decode", V_DECODE, M_NOSEL);
        push("addx0_exec", 9'b000011010, M_ALL);
        push("addx0_wb", 9'b010011010, M_ALL);
        push("addx0_idle", V_IDLE, M_NOSEL);
        tick(); tick(); tick(); tick();
        chk("addx0_rw", {59'd0, rw}, 64'd0);
        chk("instret_after_5", instret, RET5);

        // Reset during EXEC of an LD aborts it
        run = 1'b1;
        prog.push_back(32'h00803083);
        push("ldabort_fetch", V_FETCH, M_NOSEL);
        push("ldabort_decode", V_DECODE, M_NOSEL);
        push("ldabort_exec", 9'b000000010, M_ALL);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort_vec", {55'd0, ovec()}, 64'd0);
        chk("abort_imm", imm, 64'd0);
        chk("abort_rw", {59'd0, rw}, 64'd0);
        chk("abort_instret", instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b0;
        push("abort_idle0", V_IDLE, M_ALL);
        push("abort_idle1", V_IDLE, M_ALL);
        tick(); tick();

        // All-zero instruction traps; run is ignored in TRAP
        run = 1'b1;
        prog.push_back(32'h00000000);
        push("zero_fetch", V_FETCH, M_NOSEL);
        push("zero_decode", V_DECODE, M_NOSEL);
        push("zero_trap", V_TRAP, M_NOSEL);
        push("zero_trap_hold0", V_TRAP, M_NOSEL);
        push("zero_trap_hold1", V_TRAP, M_NOSEL);
        tick(); tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("trap_reset_illegal", {63'd0, illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsupported funct7 on OP opcode traps
        prog.push_back(32'h021101B3);
        push("f7_fetch", V_FETCH, M_NOSEL);
        push("f7_decode", V_DECODE, M_NOSEL);
        push("f7_trap", V_TRAP, M_NOSEL);
        tick(); tick(); tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
